// File: rtl/rb_fifo_drain_ser.sv
// Drains the ring-buffer FIFO and shifts each word out LSB-first over a 1-bit valid/ready stream.
// Define RB_DRAIN_PARITY_EN to append an even-parity bit to every frame.
//
// state | meaning
// IDLE  | no word held; pops whenever the FIFO is non-empty
// SHIFT | word held in shreg; data bits offered one per handshake
// PAR   | parity bit offered after the last data bit (RB_DRAIN_PARITY_EN only)
module rb_fifo_drain_ser #(
  parameter int MSBD = 1,
  parameter int MSBC = 7
) (
  input  logic            clock,
  input  logic            rst,
  input  logic [MSBD:0]   fifo_dataOut,
  input  logic            fifo_empty,
  input  logic            fifo_full,
  input  logic            fifo_push,
  output logic            pop,
  output logic            ser_data,
  output logic            ser_valid,
  input  logic            ser_ready,
  output logic            ser_last,
  output logic            busy,
  output logic [MSBC:0]   word_cnt
);

  localparam int W  = MSBD + 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(MSBD);

`ifdef RB_DRAIN_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t          state, state_nxt;
  logic [MSBD:0]   shreg;
  logic [BW-1:0]   bit_cnt;
  logic            pop_eff;
  logic            accept;
  logic            last_bit;
  logic            frame_done;
`ifdef RB_DRAIN_PARITY_EN
  logic            par;
`endif

  // A push into a non-full FIFO wins over a pop in the same cycle, so that pop is lost.
  assign pop_eff  = pop & ~fifo_empty & ~(fifo_push & ~fifo_full);
  assign accept   = ser_valid & ser_ready;
  assign last_bit = (bit_cnt == LAST_IDX);
`ifdef RB_DRAIN_PARITY_EN
  assign frame_done = (state == PAR) & accept;
`else
  assign frame_done = (state == SHIFT) & accept & last_bit;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pop_eff) state_nxt = SHIFT;
`ifdef RB_DRAIN_PARITY_EN
      SHIFT: if (accept && last_bit) state_nxt = PAR;
      PAR:   if (accept) state_nxt = IDLE;
`else
      SHIFT: if (accept && last_bit) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: pop = ~fifo_empty;
        SHIFT: begin
          ser_valid = 1'b1;
          ser_data  = shreg[0];
`ifdef RB_DRAIN_PARITY_EN
          ser_last  = 1'b0;
`else
          ser_last  = last_bit;
`endif
          busy      = 1'b1;
        end
`ifdef RB_DRAIN_PARITY_EN
        PAR: begin
          ser_valid = 1'b1;
          ser_data  = par;
          ser_last  = 1'b1;
          busy      = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
`ifdef RB_DRAIN_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      if (state == IDLE && pop_eff) begin
        shreg   <= fifo_dataOut;
        bit_cnt <= '0;
`ifdef RB_DRAIN_PARITY_EN
        par     <= ^fifo_dataOut;
`endif
      end else if (state == SHIFT && accept) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (frame_done) word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rb_fifo_drain_ser.sv
// Directed bench for rb_fifo_drain_ser with a small behavioural ring-buffer FIFO in front of it.
// Covers single word, push/pop collision, backpressure, full FIFO, mid-frame reset, counter wrap and parity.
module tb_rb_fifo_drain_ser;
  localparam int MSBD = 1;
  localparam int MSBC = 7;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic [MSBD:0] fifo_dataOut;
  logic          fifo_empty, fifo_full;
  logic          fifo_push = 1'b0;
  logic [MSBD:0] push_data = '0;
  logic          pop, ser_data, ser_valid, ser_last, busy;
  logic          ser_ready = 1'b1;
  logic [MSBC:0] word_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rb_fifo_drain_ser #(.MSBD(MSBD), .MSBC(MSBC)) dut (
    .clock(clock), .rst(rst), .fifo_dataOut(fifo_dataOut), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_push(fifo_push), .pop(pop), .ser_data(ser_data),
    .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last), .busy(busy),
    .word_cnt(word_cnt)
  );

  // 4-deep FIFO, push has priority over pop unless full
  logic [MSBD:0] mem [4];
  int            cnt;
  assign fifo_dataOut = mem[0];
  assign fifo_empty   = (cnt == 0);
  assign fifo_full    = (cnt == 4);

  always @(posedge clock or posedge rst) begin
    if (rst) cnt <= 0;
    else if (fifo_push && !fifo_full) begin
      mem[cnt] <= push_data;
      cnt      <= cnt + 1;
    end else if (pop && !fifo_empty) begin
      for (int i = 0; i < 3; i++) mem[i] <= mem[i+1];
      cnt <= cnt - 1;
    end
  end

  // every accepted serial bit, in order
  logic log_d[$];
  logic log_l[$];
  always @(posedge clock) begin
    if (!rst && ser_valid && ser_ready) begin
      log_d.push_back(ser_data);
      log_l.push_back(ser_last);
    end
  end

  logic exp_d[$];
  logic exp_l[$];

  function automatic void add_frame(input logic [MSBD:0] w);
`ifdef RB_DRAIN_PARITY_EN
    for (int i = 0; i <= MSBD; i++) begin exp_d.push_back(w[i]); exp_l.push_back(1'b0); end
    exp_d.push_back(^w);
    exp_l.push_back(1'b1);
`else
    for (int i = 0; i <= MSBD; i++) begin exp_d.push_back(w[i]); exp_l.push_back(i == MSBD); end
`endif
  endfunction

  task automatic compare_log(input string name, input int base);
    checks++;
    if (log_d.size() - base != exp_d.size()) begin
      errors++;
      $display("FAIL %s_len got %0d expected %0d", name, log_d.size() - base, exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (log_d[base+i] !== exp_d[i] || log_l[base+i] !== exp_l[i]) begin
          errors++;
          $display("FAIL %s_bit%0d got data=%b last=%b expected data=%b last=%b",
                   name, i, log_d[base+i], log_l[base+i], exp_d[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(fifo_empty && !busy) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got busy=%b empty=%b expected idle", name, busy, fifo_empty);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    fifo_push = 1'b0;
    ser_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_word(input logic [MSBD:0] w);
    fifo_push = 1'b1;
    push_data = w;
    @(negedge clock);
    fifo_push = 1'b0;
    @(negedge clock);
    wait_idle("send");
  endtask

  task automatic test_reset;
    @(negedge clock);
    checks++;
    if ({pop, ser_valid, ser_data, ser_last, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 00000", {pop, ser_valid, ser_data, ser_last, busy});
    end
    checks++;
    if (word_cnt !== '0) begin errors++; $display("FAIL reset_word_cnt got %0d expected 0", word_cnt); end
    do_reset;
    checks++;
    if (busy !== 1'b0 || pop !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b pop=%b expected 0 0", busy, pop);
    end
  endtask

  task automatic test_single;
    do_reset;
    fifo_push = 1'b1;
    push_data = 2'b10;
    @(negedge clock);
    fifo_push = 1'b0;
    checks++;
    if (pop !== 1'b1) begin errors++; $display("FAIL single_pop got %b expected 1", pop); end
    @(negedge clock);
    checks++;
    if ({pop, ser_valid, ser_data, ser_last, fifo_empty} !== 5'b01001) begin
      errors++;
      $display("FAIL single_bit0 got %b expected 01001", {pop, ser_valid, ser_data, ser_last, fifo_empty});
    end
    @(negedge clock);
    checks++;
`ifdef RB_DRAIN_PARITY_EN
    if ({ser_valid, ser_data, ser_last} !== 3'b110) begin
      errors++;
      $display("FAIL single_bit1 got %b expected 110", {ser_valid, ser_data, ser_last});
    end
    @(negedge clock);
    checks++;
    if ({ser_valid, ser_data, ser_last} !== 3'b111) begin
      errors++;
      $display("FAIL single_par got %b expected 111", {ser_valid, ser_data, ser_last});
    end
`else
    if ({ser_valid, ser_data, ser_last} !== 3'b111) begin
      errors++;
      $display("FAIL single_bit1 got %b expected 111", {ser_valid, ser_data, ser_last});
    end
`endif
    @(negedge clock);
    checks++;
    if (ser_valid !== 1'b0 || word_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_done got valid=%b word_cnt=%0d expected 0 1", ser_valid, word_cnt);
    end
  endtask

  task automatic test_collision;
    int base;
    do_reset;
    base = log_d.size();
    exp_d = {};
    exp_l = {};
    add_frame(2'b01);
    add_frame(2'b11);
    fifo_push = 1'b1;
    push_data = 2'b01;
    @(negedge clock);
    push_data = 2'b11;
    checks++;
    if (pop !== 1'b1) begin errors++; $display("FAIL coll_pop1 got %b expected 1", pop); end
    @(negedge clock);
    fifo_push = 1'b0;
    checks++;
    if (busy !== 1'b0 || pop !== 1'b1) begin
      errors++;
      $display("FAIL coll_retry got busy=%b pop=%b expected 0 1", busy, pop);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL coll_capture got busy=%b expected 1", busy); end
    wait_idle("coll");
    compare_log("coll", base);
    checks++;
    if (word_cnt !== 8'd2) begin errors++; $display("FAIL coll_word_cnt got %0d expected 2", word_cnt); end
  endtask

  task automatic test_backpressure;
    int base;
    do_reset;
    base = log_d.size();
    exp_d = {};
    exp_l = {};
    add_frame(2'b10);
    fifo_push = 1'b1;
    push_data = 2'b10;
    @(negedge clock);
    fifo_push = 1'b0;
    @(negedge clock);
    @(negedge clock);
    ser_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
`ifdef RB_DRAIN_PARITY_EN
      if ({ser_valid, ser_data, ser_last, busy} !== 4'b1101) begin
        errors++;
        $display("FAIL bp_hold%0d got %b expected 1101", i, {ser_valid, ser_data, ser_last, busy});
      end
`else
      if ({ser_valid, ser_data, ser_last, busy} !== 4'b1111) begin
        errors++;
        $display("FAIL bp_hold%0d got %b expected 1111", i, {ser_valid, ser_data, ser_last, busy});
      end
`endif
    end
    ser_ready = 1'b1;
    wait_idle("bp");
    compare_log("bp", base);
    checks++;
    if (word_cnt !== 8'd1) begin errors++; $display("FAIL bp_word_cnt got %0d expected 1", word_cnt); end
  endtask

  task automatic test_full;
    int base;
    do_reset;
    base = log_d.size();
    exp_d = {};
    exp_l = {};
    for (int i = 0; i < 4; i++) add_frame(2'(i));
    fifo_push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_data = 2'(i);
      @(negedge clock);
    end
    push_data = 2'b00;
    checks++;
    if (fifo_full !== 1'b1 || pop !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_pre got full=%b pop=%b busy=%b expected 1 1 0", fifo_full, pop, busy);
    end
    @(negedge clock);
    fifo_push = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL full_first_pop got busy=%b expected 1", busy); end
    wait_idle("full");
    compare_log("full", base);
    checks++;
    if (word_cnt !== 8'd4) begin errors++; $display("FAIL full_word_cnt got %0d expected 4", word_cnt); end
  endtask

  task automatic test_midreset;
    int base;
    do_reset;
    fifo_push = 1'b1;
    push_data = 2'b11;
    @(negedge clock);
    fifo_push = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (ser_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre got valid=%b expected 1", ser_valid); end
    base = log_d.size();
    rst = 1'b1;
    #1;
    checks++;
    if ({ser_valid, ser_data, ser_last, busy, pop} !== 5'b0 || word_cnt !== '0) begin
      errors++;
      $display("FAIL mrst_async got %b word_cnt=%0d expected 00000 0",
               {ser_valid, ser_data, ser_last, busy, pop}, word_cnt);
    end
    @(negedge clock);
    rst = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (log_d.size() != base || ser_valid !== 1'b0 || word_cnt !== '0) begin
      errors++;
      $display("FAIL mrst_after got bits=%0d valid=%b word_cnt=%0d expected 0 0 0",
               log_d.size() - base, ser_valid, word_cnt);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    for (int i = 0; i < 256; i++) send_word(2'(i));
    checks++;
    if (word_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d expected 0", word_cnt); end
    send_word(2'b01);
    checks++;
    if (word_cnt !== 8'd1) begin errors++; $display("FAIL wrap_one got %0d expected 1", word_cnt); end
  endtask

`ifdef RB_DRAIN_PARITY_EN
  task automatic test_parity;
    int base;
    do_reset;
    base = log_d.size();
    exp_d = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_l = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    send_word(2'b11);
    send_word(2'b10);
    compare_log("par", base);
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_collision;
    test_backpressure;
    test_full;
    test_midreset;
    test_wrap;
`ifdef RB_DRAIN_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
